// File: rtl/uart_mmio_ctrl.sv
// uart_mmio_ctrl
//   Memory-mapped bridge between the CPU load/store path and the on-chip UART.
//   Decodes the 0x8000_00xx window, buffers received bytes in a small FIFO,
//   holds one outgoing byte for the transmitter and keeps cycle / retired-
//   instruction counters for software benchmarking.
// Ports
//   clk_i, rst_n_i          clock, async active-low reset
//   addr_i, wdata_i         CPU address / store data (addr_i[1:0] ignored)
//   wen_i, ren_i            one-cycle store / load strobes
//   rdata_o                 registered load data, valid the cycle after ren_i
//   instr_retire_i          one pulse per retired instruction
//   rx_data_i/valid_i/ready_o   byte stream from the UART receiver
//   tx_data_o/valid_o/ready_i   byte stream to the UART transmitter
module uart_mmio_ctrl #(
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic        wen_i,
    input  logic        ren_i,
    output logic [31:0] rdata_o,
    input  logic        instr_retire_i,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    output logic        rx_ready_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_valid_o,
    input  logic        tx_ready_i
);
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    // Word-address decode (byte address >> 2)
    logic [29:0] word;
    logic sel_stat, sel_rxd, sel_txd, sel_cyc, sel_ins, sel_clr;
    assign word     = addr_i[31:2];
    assign sel_stat = (word == 30'h2000_0000);
    assign sel_rxd  = (word == 30'h2000_0001);
    assign sel_txd  = (word == 30'h2000_0002);
    assign sel_cyc  = (word == 30'h2000_0004);
    assign sel_ins  = (word == 30'h2000_0005);
    assign sel_clr  = (word == 30'h2000_0006);

    // State
    logic [7:0]       mem_q [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] wptr_q, rptr_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tx_valid_q, tx_valid_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_drop_q, tx_drop_d;
    logic [31:0]      cyc_q, cyc_d, ins_q, ins_d;
    logic [31:0]      rdata_q, rdata_d;

    logic fifo_empty, fifo_full, push, pop, clr, tx_wr;
    assign fifo_empty = (cnt_q == '0);
    assign fifo_full  = (cnt_q == CNT_W'(RX_FIFO_DEPTH));
    // rx_ready depends only on registered count: a same-cycle pop never opens a slot early
    assign rx_ready_o = !fifo_full;
    assign push       = rx_valid_i && !fifo_full;
    assign pop        = ren_i && sel_rxd && !fifo_empty;
    assign clr        = wen_i && sel_clr;
    assign tx_wr      = wen_i && sel_txd;

    always_comb begin
        cnt_d      = cnt_q;
        tx_valid_d = tx_valid_q;
        tx_data_d  = tx_data_q;
        tx_drop_d  = tx_drop_q;
        rdata_d    = rdata_q;

        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase

        // Acceptance looks only at tx_valid_q, so a write that coincides with
        // the transmitter draining the byte is still a drop.
        if (tx_valid_q && tx_ready_i) tx_valid_d = 1'b0;
        if (tx_wr) begin
            if (!tx_valid_q) begin
                tx_valid_d = 1'b1;
                tx_data_d  = wdata_i[7:0];
            end else begin
                tx_drop_d  = 1'b1;
            end
        end
        if (wen_i && sel_stat) tx_drop_d = 1'b0;

        // Counters: clear wins over the same-cycle increment
        cyc_d = clr ? 32'd0 : cyc_q + 32'd1;
        ins_d = clr ? 32'd0 : ins_q + 32'(instr_retire_i);

        // Read data is taken from pre-update state
        if (ren_i) begin
            rdata_d = 32'd0;
            if (sel_stat)
                rdata_d = {28'd0, tx_drop_q, 1'b0, !fifo_empty, !tx_valid_q};
            else if (sel_rxd && !fifo_empty)
                rdata_d = {24'd0, mem_q[rptr_q]};
            else if (sel_cyc)
                rdata_d = cyc_q;
            else if (sel_ins)
                rdata_d = ins_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            tx_drop_q  <= 1'b0;
            cyc_q      <= '0;
            ins_q      <= '0;
            rdata_q    <= '0;
        end else begin
            if (push) begin
                mem_q[wptr_q] <= rx_data_i;
                wptr_q        <= wptr_q + PTR_W'(1);
            end
            if (pop) rptr_q <= rptr_q + PTR_W'(1);
            cnt_q      <= cnt_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            tx_drop_q  <= tx_drop_d;
            cyc_q      <= cyc_d;
            ins_q      <= ins_d;
            rdata_q    <= rdata_d;
        end
    end

    assign rdata_o    = rdata_q;
    assign tx_data_o  = tx_data_q;
    assign tx_valid_o = tx_valid_q;
endmodule

// File: tb/tb_uart_mmio_ctrl.sv
module tb_uart_mmio_ctrl;
    localparam logic [31:0] A_STAT = 32'h8000_0000;
    localparam logic [31:0] A_RXD  = 32'h8000_0004;
    localparam logic [31:0] A_TXD  = 32'h8000_0008;
    localparam logic [31:0] A_CYC  = 32'h8000_0010;
    localparam logic [31:0] A_INS  = 32'h8000_0014;
    localparam logic [31:0] A_CLR  = 32'h8000_0018;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        wen_i = 1'b0;
    logic        ren_i = 1'b0;
    logic [31:0] rdata_o;
    logic        instr_retire_i = 1'b0;
    logic [7:0]  rx_data_i = '0;
    logic        rx_valid_i = 1'b0;
    logic        rx_ready_o;
    logic [7:0]  tx_data_o;
    logic        tx_valid_o;
    logic        tx_ready_i = 1'b0;

    uart_mmio_ctrl dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .wen_i(wen_i), .ren_i(ren_i), .rdata_o(rdata_o),
        .instr_retire_i(instr_retire_i), .rx_data_i(rx_data_i),
        .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o), .tx_data_o(tx_data_o),
        .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i)
    );

    always #5 clk_i = ~clk_i;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    string       nm_q[$];
    logic        rd_pend = 1'b0;

    // Monitor: a load issued at an edge presents rdata after that edge
    always @(posedge clk_i) rd_pend <= ren_i && rst_n_i;

    always @(negedge clk_i) begin
        if (rd_pend) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rdata_unexpected got=%08h (no expected entry)", rdata_o);
            end else begin
                logic [31:0] e;
                string n;
                e = exp_q.pop_front();
                n = nm_q.pop_front();
                if (rdata_o !== e) begin
                    errors++;
                    $display("FAIL %s got=%08h exp=%08h", n, rdata_o, e);
                end
            end
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", n, act, exp);
        end
    endtask

    // One bus cycle; starts and ends just after a rising edge
    task automatic bus(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] e, input string n);
        ren_i = r; wen_i = w; addr_i = a; wdata_i = d;
        if (r) begin exp_q.push_back(e); nm_q.push_back(n); end
        @(posedge clk_i); #1;
        ren_i = 1'b0; wen_i = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] e, input string n);
        bus(1'b1, 1'b0, a, 32'd0, e, n);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(1'b0, 1'b1, a, d, 32'd0, "");
    endtask

    task automatic push(input logic [7:0] b);
        rx_valid_i = 1'b1; rx_data_i = b;
        @(posedge clk_i); #1;
        rx_valid_i = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk_i); #1; end
    endtask

    initial begin
        // 1. reset, then reset while busy
        #1;
        chk("rst_rdata", rdata_o, 32'd0);
        chk("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
        chk("rst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        idle(1);
        wr(A_TXD, 32'hAA);
        push(8'h01);
        push(8'h02);
        chk("pre_rst_tx_valid", {31'd0, tx_valid_o}, 32'd1);
        rst_n_i = 1'b0;
        #1;
        chk("midrst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
        chk("midrst_rx_ready", {31'd0, rx_ready_o}, 32'd1);
        chk("midrst_tx_data", {24'd0, tx_data_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_n_i = 1'b1;
        rd(A_STAT, 32'h1, "status_after_rst");
        rd(A_RXD, 32'h0, "fifo_empty_after_rst");

        // 2. TX holding register, drop flag
        tx_ready_i = 1'b0;
        wr(A_TXD, 32'h61);
        chk("tx_valid_set", {31'd0, tx_valid_o}, 32'd1);
        chk("tx_data_61", {24'd0, tx_data_o}, 32'h61);
        rd(A_STAT, 32'h0, "status_tx_busy");
        wr(A_TXD, 32'h62);
        rd(A_STAT, 32'h8, "status_drop");
        chk("tx_data_kept", {24'd0, tx_data_o}, 32'h61);
        bus(1'b1, 1'b1, A_STAT, 32'd0, 32'h8, "rw_status_old_value");
        rd(A_STAT, 32'h0, "status_drop_cleared");
        // drain and write in the same cycle: write still dropped
        tx_ready_i = 1'b1;
        wr(A_TXD, 32'h63);
        tx_ready_i = 1'b0;
        chk("tx_valid_drained", {31'd0, tx_valid_o}, 32'd0);
        chk("tx_data_hold", {24'd0, tx_data_o}, 32'h61);
        rd(A_STAT, 32'h9, "status_drop_on_drain");
        wr(A_STAT, 32'hFFFF_FFFF);
        rd(A_STAT, 32'h1, "status_idle");

        // 3. fill FIFO, stall 5th byte
        rx_valid_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rx_data_i = 8'h61 + 8'(i);
            @(posedge clk_i); #1;
        end
        rx_data_i = 8'h65;
        chk("rx_full", {31'd0, rx_ready_o}, 32'd0);
        idle(2);
        chk("rx_stall", {31'd0, rx_ready_o}, 32'd0);
        rd(A_RXD, 32'h61, "rx_pop0");
        chk("rx_ready_after_pop", {31'd0, rx_ready_o}, 32'd1);
        rd(A_RXD, 32'h62, "rx_pop1");   // 0x65 pushed on this edge
        rx_valid_i = 1'b0;
        rd(A_RXD, 32'h63, "rx_pop2");
        rd(A_RXD, 32'h64, "rx_pop3");
        rd(A_RXD, 32'h65, "rx_pop4");
        rd(A_RXD, 32'h0, "rx_pop_empty");

        // 4. simultaneous push and pop
        push(8'h11);
        push(8'h22);
        rx_valid_i = 1'b1; rx_data_i = 8'h70;
        rd(A_RXD, 32'h11, "pushpop_head");
        rx_valid_i = 1'b0;
        rd(A_STAT, 32'h3, "status_rx_avail");
        rd(A_RXD, 32'h22, "pushpop_next");
        rd(A_RXD, 32'h70, "pushpop_pushed");
        rd(A_RXD, 32'h0, "pushpop_empty");

        // 5. counters
        wr(A_CLR, 32'd0);
        for (int i = 0; i < 20; i++) begin
            instr_retire_i = (i % 3 == 0);
            @(posedge clk_i); #1;
        end
        instr_retire_i = 1'b0;
        rd(A_INS, 32'd7, "instr_count");
        instr_retire_i = 1'b1;
        wr(A_CLR, 32'd0);
        instr_retire_i = 1'b0;
        rd(A_INS, 32'd0, "instr_clear_wins");
        wr(A_CLR, 32'd0);
        rd(A_CYC, 32'd0, "cycle_k1");
        wr(A_CLR, 32'd0);
        idle(4);
        rd(A_CYC, 32'd4, "cycle_k5");

        // 6. unmapped / read-only accesses
        push(8'h33);
        wr(A_TXD, 32'h44);
        rd(32'h8000_0020, 32'h0, "unmapped_read");
        wr(A_RXD, 32'hFF);
        wr(32'h8000_0108, 32'h55);
        rd(32'h8000_0003, 32'h2, "status_lsb_ignored");
        chk("tx_data_unchanged", {24'd0, tx_data_o}, 32'h44);
        chk("tx_valid_unchanged", {31'd0, tx_valid_o}, 32'd1);
        rd(A_RXD, 32'h33, "fifo_unchanged");

        idle(2);
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
